// File: rtl/deco_reg.sv
// Three 4-bit holding registers; a 2-bit select chooses at most one of them to load per clock.
// Select 00 is the idle slot of the scan count, so every register holds during it.
module deco_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Entrada_Contador,
    input  logic [3:0] Entrada1,
    input  logic [3:0] Entrada2,
    input  logic [3:0] Entrada3,
    output logic [3:0] Salida1,
    output logic [3:0] Salida2,
    output logic [3:0] Salida3
);

    logic [2:0] load_en;

    // One-hot decode. Any illegal select value, including X/Z, falls to the
    // default and produces a hold.
    always_comb begin
        load_en = 3'b000;
        case (Entrada_Contador)
            2'b01:   load_en = 3'b001;
            2'b10:   load_en = 3'b010;
            2'b11:   load_en = 3'b100;
            default: load_en = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Salida1 <= 4'h0;
        end else if (load_en[0]) begin
            Salida1 <= Entrada1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Salida2 <= 4'h0;
        end else if (load_en[1]) begin
            Salida2 <= Entrada2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Salida3 <= 4'h0;
        end else if (load_en[2]) begin
            Salida3 <= Entrada3;
        end
    end

endmodule

// File: tb/tb_deco_reg.sv
// Directed bench for deco_reg. The driver queues the hand-computed register contents
// for each step, and the monitor compares them with the outputs whenever it is strobed.
module tb_deco_reg;

    logic       clk;
    logic       reset;
    logic [1:0] sel;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;

    logic [11:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          errors;
    event        mon_ev;

    deco_reg dut (
        .clk              (clk),
        .reset            (reset),
        .Entrada_Contador (sel),
        .Entrada1         (d1),
        .Entrada2         (d2),
        .Entrada3         (d3),
        .Salida1          (q1),
        .Salida2          (q2),
        .Salida3          (q3)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic push_exp(input string nm, input logic [3:0] e1, input logic [3:0] e2,
                            input logic [3:0] e3);
        exp_q.push_back({e1, e2, e3});
        name_q.push_back(nm);
    endtask

    // Inputs change on the falling edge; the outputs are sampled 1 time unit after the rising edge.
    task automatic step(input string nm, input logic [1:0] s, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input logic [3:0] e1,
                        input logic [3:0] e2, input logic [3:0] e3);
        @(negedge clk);
        sel = s;
        d1  = a;
        d2  = b;
        d3  = c;
        @(posedge clk);
        push_exp(nm, e1, e2, e3);
        #1;
        -> mon_ev;
    endtask

    // Assert reset between clock edges and check the cleared outputs before any rising edge.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        push_exp(nm, 4'h0, 4'h0, 4'h0);
        -> mon_ev;
    endtask

    task automatic release_reset();
        @(negedge clk);
        sel   = 2'b00;
        reset = 1'b1;
    endtask

    // Scoreboard monitor
    initial begin
        logic [11:0] exp;
        string       nm;
        forever begin
            @(mon_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: output presented with empty expected queue", "monitor");
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if ({q1, q2, q3} !== exp) begin
                    errors++;
                    $display("FAIL %s: got %h/%h/%h expected %h/%h/%h", nm, q1, q2, q3,
                             exp[11:8], exp[7:4], exp[3:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        sel    = 2'b00;
        d1     = 4'h0;
        d2     = 4'h0;
        d3     = 4'h0;
        repeat (2) @(negedge clk);
        release_reset();

        // Preload nonzero values, then show that reset clears them asynchronously.
        step("pre_load1", 2'b01, 4'h7, 4'h8, 4'h9, 4'h7, 4'h0, 4'h0);
        step("pre_load2", 2'b10, 4'h7, 4'h8, 4'h9, 4'h7, 4'h8, 4'h0);
        step("pre_load3", 2'b11, 4'h7, 4'h8, 4'h9, 4'h7, 4'h8, 4'h9);
        async_reset("reset_async");
        step("reset_hold_a", 2'b01, 4'h7, 4'h8, 4'h9, 4'h0, 4'h0, 4'h0);
        step("reset_hold_b", 2'b11, 4'h7, 4'h8, 4'h9, 4'h0, 4'h0, 4'h0);
        release_reset();

        // Sequential fill.
        step("fill1", 2'b01, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0);
        step("fill2", 2'b10, 4'h1, 4'h2, 4'h0, 4'h1, 4'h2, 4'h0);
        step("fill3", 2'b11, 4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3);

        // Hold on 00 while every data input changes.
        step("hold00_a", 2'b00, 4'hA, 4'hA, 4'hA, 4'h1, 4'h2, 4'h3);
        step("hold00_b", 2'b00, 4'hA, 4'hA, 4'hA, 4'h1, 4'h2, 4'h3);

        // Overwrite pass: each old value holds until its own load edge.
        step("ovw1", 2'b01, 4'hF, 4'hA, 4'hA, 4'hF, 4'h2, 4'h3);
        step("ovw2", 2'b10, 4'hF, 4'hE, 4'hA, 4'hF, 4'hE, 4'h3);
        step("ovw3", 2'b11, 4'hF, 4'hE, 4'hD, 4'hF, 4'hE, 4'hD);

        // Isolation with select held at 10.
        step("iso_a", 2'b10, 4'h1, 4'h5, 4'h2, 4'hF, 4'h5, 4'hD);
        step("iso_b", 2'b10, 4'h3, 4'h6, 4'h4, 4'hF, 4'h6, 4'hD);
        step("iso_c", 2'b10, 4'h7, 4'h9, 4'h8, 4'hF, 4'h9, 4'hD);
        step("iso_d", 2'b10, 4'h0, 4'hE, 4'h0, 4'hF, 4'hE, 4'hD);

        // Wrap 11 -> 00 -> 01 holds through the idle slot.
        step("wrap11", 2'b11, 4'h0, 4'h0, 4'hD, 4'hF, 4'hE, 4'hD);
        step("wrap00", 2'b00, 4'h0, 4'h0, 4'h0, 4'hF, 4'hE, 4'hD);
        step("wrap01", 2'b01, 4'hF, 4'h0, 4'h0, 4'hF, 4'hE, 4'hD);

        // Mid-sequence reset, then refill only the register whose select recurs.
        async_reset("midreset");
        release_reset();
        step("refill1", 2'b01, 4'h5, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0);
        step("refill_hold", 2'b00, 4'h6, 4'h6, 4'h6, 4'h5, 4'h0, 4'h0);

        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
